// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline controller: state encoding and
// the per-state stage-enable decode.
package pipeline_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        WARMUP_1 = 3'd1,
        WARMUP_2 = 3'd2,
        WARMUP_3 = 3'd3,
        RUN      = 3'd4,
        PAUSE    = 3'd5,
        HALT     = 3'd6
    } pipeline_t;

    localparam int STALL_W_DEFAULT = 16;

    // Returns {fetch, decode, exec, write} enables.
    function automatic logic [3:0] stage_en(pipeline_t s);
        logic [3:0] en;
        en = 4'b0000;
        case (s)
            WARMUP_1: en = 4'b1000;
            WARMUP_2: en = 4'b1100;
            WARMUP_3: en = 4'b1110;
            RUN:      en = 4'b1111;
            default:  en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing FSM: warm-up fill, stall pause/resume,
// redirect refill with one-cycle flush, and absorbing halt.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = STALL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             decode_ready,
    input  logic             exec_ready,
    input  logic             write_ready,
    input  logic             redirect,
    input  logic             halt,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             write_en,
    output logic             flush,
    output pipeline_t        state,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    pipeline_t r_state;
    pipeline_t r_saved;
    logic      r_flush;

    pipeline_t w_next;
    pipeline_t w_saved_next;
    logic      w_all_ready;
    logic      w_redirect_ok;

    assign w_all_ready = fetch_ready & decode_ready
                       & exec_ready & write_ready;

    assign w_redirect_ok = redirect && w_all_ready && !halt
                        && ((r_state == WARMUP_3) || (r_state == RUN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= INIT;
            r_saved <= INIT;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_next;
            r_saved <= w_saved_next;
            r_flush <= w_redirect_ok;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_saved_next = r_saved;
        if (halt || (r_state == HALT)) begin
            w_next = HALT;
        end else if (!w_all_ready) begin
            w_next = PAUSE;
            // Keep the pre-stall state across a multi-cycle pause.
            if (r_state != PAUSE) begin
                w_saved_next = r_state;
            end
        end else if (w_redirect_ok) begin
            w_next = WARMUP_1;
        end else begin
            case (r_state)
                INIT:     w_next = WARMUP_1;
                WARMUP_1: w_next = WARMUP_2;
                WARMUP_2: w_next = WARMUP_3;
                WARMUP_3: w_next = RUN;
                RUN:      w_next = RUN;
                PAUSE:    w_next = r_saved;
                default:  w_next = INIT;
            endcase
        end
    end

    assign {fetch_en, decode_en, exec_en, write_en} = stage_en(r_state);

    assign flush  = r_flush;
    assign state  = r_state;
    assign halted = (r_state == HALT);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_state == PAUSE),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl; a 4-bit-counter copy shares
// the stimulus to exercise stall-counter saturation.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       halt;
    logic       redirect;
    logic [3:0] rdy;

    logic       fe_a, de_a, ex_a, wr_a, fl_a, hd_a;
    pipeline_t  st_a;
    logic [15:0] sc_a;
    logic       fe_b, de_b, ex_b, wr_b, fl_b, hd_b;
    pipeline_t  st_b;
    logic [3:0] sc_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic      rs;
        logic      hl;
        logic      rd;
        logic [3:0] rdy;
        pipeline_t st;
        logic      fl;
        int        s16;
        int        s4;
    } vec_t;

    logic [28:0] sb[$];

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .fetch_ready(rdy[3]), .decode_ready(rdy[2]),
        .exec_ready(rdy[1]), .write_ready(rdy[0]),
        .redirect(redirect), .halt(halt),
        .fetch_en(fe_a), .decode_en(de_a),
        .exec_en(ex_a), .write_en(wr_a),
        .flush(fl_a), .state(st_a), .halted(hd_a),
        .stall_cycles(sc_a)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .fetch_ready(rdy[3]), .decode_ready(rdy[2]),
        .exec_ready(rdy[1]), .write_ready(rdy[0]),
        .redirect(redirect), .halt(halt),
        .fetch_en(fe_b), .decode_en(de_b),
        .exec_en(ex_b), .write_en(wr_b),
        .flush(fl_b), .state(st_b), .halted(hd_b),
        .stall_cycles(sc_b)
    );

    function automatic logic [3:0] exp_en(pipeline_t s);
        if (s == RUN) return 4'b1111;
        if (s == WARMUP_3) return 4'b1110;
        if (s == WARMUP_2) return 4'b1100;
        if (s == WARMUP_1) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic vec_t mk(logic rs, logic hl, logic rd,
                                logic [3:0] r, pipeline_t st,
                                logic fl, int s16, int s4);
        vec_t v;
        v.rs = rs; v.hl = hl; v.rd = rd; v.rdy = r;
        v.st = st; v.fl = fl; v.s16 = s16; v.s4 = s4;
        return v;
    endfunction

    function automatic logic [28:0] exp_of(vec_t v);
        logic [15:0] s16;
        logic [3:0]  s4;
        s16 = v.s16[15:0];
        s4  = v.s4[3:0];
        return {v.st, exp_en(v.st), v.fl, (v.st == HALT), s16, s4};
    endfunction

    task automatic test_reset();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(0, 1, 1, 4'h0, INIT, 0, 0, 0));
        q.push_back(mk(0, 1, 1, 4'h0, INIT, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 4'hF, INIT, 0, 0, 0));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e || st_b !== st_a) begin
                n_err++;
                $display("FAIL reset step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_warmup();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_1, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_2, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_3, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 0, 0));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL warmup step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_pause_run();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(1, 0, 0, 4'b1101, PAUSE, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'b1101, PAUSE, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'b1101, PAUSE, 0, 2, 2));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 3, 3));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 3, 3));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pause_run step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_pause_warmup();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(0, 0, 0, 4'hF, INIT, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_1, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_2, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'b1110, PAUSE, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_2, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_3, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 1, 1));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pause_warmup step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_redirect();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(1, 0, 1, 4'hF, WARMUP_1, 1, 1, 1));
        q.push_back(mk(1, 0, 1, 4'hF, WARMUP_2, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_3, 0, 1, 1));
        q.push_back(mk(1, 0, 1, 4'hF, WARMUP_1, 1, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_2, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_3, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 1, 1));
        q.push_back(mk(1, 0, 1, 4'b0111, PAUSE, 0, 1, 1));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 2, 2));
        q.push_back(mk(1, 0, 0, 4'hF, RUN, 0, 2, 2));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL redirect step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_halt();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(1, 1, 1, 4'b1101, HALT, 0, 2, 2));
        q.push_back(mk(1, 0, 1, 4'hF, HALT, 0, 2, 2));
        q.push_back(mk(1, 0, 0, 4'h0, HALT, 0, 2, 2));
        q.push_back(mk(1, 0, 0, 4'hF, HALT, 0, 2, 2));
        q.push_back(mk(0, 1, 1, 4'h0, INIT, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_1, 0, 0, 0));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL halt step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_saturate();
        vec_t q[$];
        logic [28:0] e, o;
        q.push_back(mk(0, 0, 0, 4'hF, INIT, 0, 0, 0));
        for (int k = 1; k <= 20; k++)
            q.push_back(mk(1, 0, 0, 4'b1011, PAUSE, 0, k - 1,
                           (k - 1 > 15) ? 15 : k - 1));
        q.push_back(mk(1, 0, 0, 4'hF, INIT, 0, 20, 15));
        q.push_back(mk(1, 0, 0, 4'hF, WARMUP_1, 0, 20, 15));
        q.push_back(mk(0, 0, 0, 4'hF, INIT, 0, 0, 0));
        foreach (q[i]) begin
            rst = q[i].rs; halt = q[i].hl;
            redirect = q[i].rd; rdy = q[i].rdy;
            sb.push_back(exp_of(q[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {st_a, fe_a, de_a, ex_a, wr_a, fl_a, hd_a, sc_a, sc_b};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL saturate step %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0; halt = 1'b0; redirect = 1'b0; rdy = 4'h0;
        #1;
        test_reset();
        test_warmup();
        test_pause_run();
        test_pause_warmup();
        test_redirect();
        test_halt();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
